// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU operation codes and the decoded bundle.
// Immediates are held as 32-bit sign-carrying values and widened to XLEN at the consumer.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [5:0] ALU_LB   = 6'd0,  ALU_LH    = 6'd1,  ALU_LW    = 6'd2;
    localparam logic [5:0] ALU_LBU  = 6'd3,  ALU_LHU   = 6'd4;
    localparam logic [5:0] ALU_ADDI = 6'd5,  ALU_SLTI  = 6'd6,  ALU_SLTIU = 6'd7;
    localparam logic [5:0] ALU_XORI = 6'd8,  ALU_ORI   = 6'd9,  ALU_ANDI  = 6'd10;
    localparam logic [5:0] ALU_SLLI = 6'd11, ALU_SRLI  = 6'd12, ALU_SRAI  = 6'd13;
    localparam logic [5:0] ALU_AUIPC = 6'd14;
    localparam logic [5:0] ALU_SB   = 6'd15, ALU_SH    = 6'd16, ALU_SW    = 6'd17;
    localparam logic [5:0] ALU_ADD  = 6'd18, ALU_SUB   = 6'd19, ALU_SLL   = 6'd20;
    localparam logic [5:0] ALU_SLT  = 6'd21, ALU_SLTU  = 6'd22, ALU_XOR   = 6'd23;
    localparam logic [5:0] ALU_SRL  = 6'd24, ALU_SRA   = 6'd25, ALU_OR    = 6'd26;
    localparam logic [5:0] ALU_AND  = 6'd27, ALU_LUI   = 6'd28;
    localparam logic [5:0] ALU_BEQ  = 6'd29, ALU_BNE   = 6'd30, ALU_BLT   = 6'd31;
    localparam logic [5:0] ALU_BGE  = 6'd32, ALU_BLTU  = 6'd33, ALU_BGEU  = 6'd34;
    localparam logic [5:0] ALU_JALR = 6'd35, ALU_JAL   = 6'd36, ALU_MUL   = 6'd37;
    localparam logic [5:0] ALU_LD   = 6'd45, ALU_LWU   = 6'd46, ALU_SD    = 6'd47;
    localparam logic [5:0] ALU_ADDIW = 6'd48, ALU_SLLIW = 6'd49, ALU_SRLIW = 6'd50;
    localparam logic [5:0] ALU_SRAIW = 6'd51, ALU_ADDW  = 6'd52, ALU_SUBW  = 6'd53;
    localparam logic [5:0] ALU_SLLW  = 6'd54, ALU_SRLW  = 6'd55, ALU_SRAW  = 6'd56;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        operand_a;
        logic        operand_b;
        logic        jalr_en;
        logic        jal_en;
        logic        branch_en;
        logic        illegal;
        logic [5:0]  alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I/RV64I(+M) decode of one instruction into the control bundle.
// No state, no handshake; illegal encodings collapse to a bundle with only the illegal flag set.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b0
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  shf;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    dec_t        d;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    // RV64 shifts borrow bit 25 as shamt[5], so it is excluded from the func7 match
    assign shf = RV64 ? {instr_i[31:26], 1'b0} : instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        d     = '0;
        legal = 1'b1;
        case (opc)
            OPC_LOAD: begin
                d.reg_write  = 1'b1;
                d.mem_to_reg = 1'b1;
                d.operand_a  = 1'b1;
                d.imm        = imm_i;
                case (f3)
                    3'd0:    d.alu_op = ALU_LB;
                    3'd1:    d.alu_op = ALU_LH;
                    3'd2:    d.alu_op = ALU_LW;
                    3'd3:    begin d.alu_op = ALU_LD;  legal = RV64; end
                    3'd4:    d.alu_op = ALU_LBU;
                    3'd5:    d.alu_op = ALU_LHU;
                    3'd6:    begin d.alu_op = ALU_LWU; legal = RV64; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.imm       = imm_i;
                case (f3)
                    3'd0: d.alu_op = ALU_ADDI;
                    3'd1: begin d.alu_op = ALU_SLLI; legal = (shf == F7_ZERO); end
                    3'd2: d.alu_op = ALU_SLTI;
                    3'd3: d.alu_op = ALU_SLTIU;
                    3'd4: d.alu_op = ALU_XORI;
                    3'd5: begin
                        d.alu_op = instr_i[30] ? ALU_SRAI : ALU_SRLI;
                        legal    = (shf == F7_ZERO) || (shf == F7_ALT);
                    end
                    3'd6:    d.alu_op = ALU_ORI;
                    default: d.alu_op = ALU_ANDI;
                endcase
            end
            OPC_AUIPC: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.operand_b = 1'b1;
                d.imm       = imm_u;
                d.alu_op    = ALU_AUIPC;
            end
            OPC_STORE: begin
                d.mem_write = 1'b1;
                d.operand_a = 1'b1;
                d.imm       = imm_s;
                case (f3)
                    3'd0:    d.alu_op = ALU_SB;
                    3'd1:    d.alu_op = ALU_SH;
                    3'd2:    d.alu_op = ALU_SW;
                    3'd3:    begin d.alu_op = ALU_SD; legal = RV64; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                d.reg_write = 1'b1;
                case (f7)
                    F7_ZERO: begin
                        case (f3)
                            3'd0:    d.alu_op = ALU_ADD;
                            3'd1:    d.alu_op = ALU_SLL;
                            3'd2:    d.alu_op = ALU_SLT;
                            3'd3:    d.alu_op = ALU_SLTU;
                            3'd4:    d.alu_op = ALU_XOR;
                            3'd5:    d.alu_op = ALU_SRL;
                            3'd6:    d.alu_op = ALU_OR;
                            default: d.alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        d.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                        legal    = (f3 == 3'd0) || (f3 == 3'd5);
                    end
                    F7_MULD: begin
                        d.alu_op = ALU_MUL + {3'b0, f3};
                        legal    = M_EXT;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.imm       = imm_u;
                d.alu_op    = ALU_LUI;
            end
            OPC_BRANCH: begin
                d.branch_en = 1'b1;
                d.imm       = imm_b;
                case (f3)
                    3'd0:    d.alu_op = ALU_BEQ;
                    3'd1:    d.alu_op = ALU_BNE;
                    3'd4:    d.alu_op = ALU_BLT;
                    3'd5:    d.alu_op = ALU_BGE;
                    3'd6:    d.alu_op = ALU_BLTU;
                    3'd7:    d.alu_op = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_JALR: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.jalr_en   = 1'b1;
                d.imm       = imm_i;
                d.alu_op    = ALU_JALR;
                legal       = (f3 == 3'd0);
            end
            OPC_JAL: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.operand_b = 1'b1;
                d.jal_en    = 1'b1;
                d.imm       = imm_j;
                d.alu_op    = ALU_JAL;
            end
            OPC_OP_IMM_32: begin
                d.reg_write = 1'b1;
                d.operand_a = 1'b1;
                d.imm       = imm_i;
                case ({f7, f3})
                    {F7_ZERO, 3'd1}: d.alu_op = ALU_SLLIW;
                    {F7_ZERO, 3'd5}: d.alu_op = ALU_SRLIW;
                    {F7_ALT,  3'd5}: d.alu_op = ALU_SRAIW;
                    default: begin
                        d.alu_op = ALU_ADDIW;
                        legal    = (f3 == 3'd0);
                    end
                endcase
                legal = legal && RV64;
            end
            OPC_OP_32: begin
                d.reg_write = 1'b1;
                case ({f7, f3})
                    {F7_ZERO, 3'd0}: d.alu_op = ALU_ADDW;
                    {F7_ALT,  3'd0}: d.alu_op = ALU_SUBW;
                    {F7_ZERO, 3'd1}: d.alu_op = ALU_SLLW;
                    {F7_ZERO, 3'd5}: d.alu_op = ALU_SRLW;
                    {F7_ALT,  3'd5}: d.alu_op = ALU_SRAW;
                    default:         legal = 1'b0;
                endcase
                legal = legal && RV64;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        d.rs1 = instr_i[19:15];
        d.rs2 = instr_i[24:20];
        d.rd  = d.reg_write ? instr_i[11:7] : 5'd0;
    end

    assign dec_o = d;

endmodule

// File: rtl/decode_pipe.sv
// Registered RISC-V decoder between fetch and execute, holding results in a two-entry skid buffer.
// Latency one cycle; in_ready depends only on buffer occupancy and rst, never on out_ready.
module decode_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [5:0]      out_aluOP,
    output logic            out_regWrite,
    output logic            out_memToReg,
    output logic            out_memWrite,
    output logic            out_operandA,
    output logic            out_operandB,
    output logic            out_jalrEN,
    output logic            out_jalEN,
    output logic            out_branchEN,
    output logic            out_illegal
);

    dec_t            dec;
    dec_t            ent_q [2];
    logic [XLEN-1:0] pc_q  [2];
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [1:0]      cnt_q,  cnt_d;
    logic            push, pop;
    dec_t            hd;

    rv_decode_comb #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT != 0)
    ) u_dec (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign in_ready  = ~cnt_q[1] & ~rst;
    assign out_valid = |cnt_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            cnt_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Entries are cleared only by reset so every out_* field reads 0 afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                ent_q[k] <= '0;
                pc_q[k]  <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            if (push) begin
                ent_q[tail_q] <= dec;
                pc_q[tail_q]  <= in_pc;
            end
        end
    end

    assign hd           = ent_q[head_q];
    assign out_pc       = pc_q[head_q];
    assign out_imm      = XLEN'($signed(hd.imm));
    assign out_rs1      = hd.rs1;
    assign out_rs2      = hd.rs2;
    assign out_rd       = hd.rd;
    assign out_aluOP    = hd.alu_op;
    assign out_regWrite = hd.reg_write;
    assign out_memToReg = hd.mem_to_reg;
    assign out_memWrite = hd.mem_write;
    assign out_operandA = hd.operand_a;
    assign out_operandB = hd.operand_b;
    assign out_jalrEN   = hd.jalr_en;
    assign out_jalEN    = hd.jal_en;
    assign out_branchEN = hd.branch_en;
    assign out_illegal  = hd.illegal;

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, parametrised RISC-V instruction decoder for the single-cycle-to-pipelined migration. It sits between fetch and execute and decodes RV32I/RV64I, optionally with the M extension, into the existing control bundle plus an illegal-instruction flag. The block holds decoded instructions in a two-entry skid buffer behind valid/ready handshakes, so fetch and execute can stall independently. Decoded instructions leave in order with one cycle of latency.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; sets immediate and PC width.
- `M_EXT`, 0: 1 enables decode of MUL/DIV/REM.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: drops all buffered and incoming instructions.
- `in_valid` in 1: fetch offers `in_instr` and `in_pc`.
- `in_ready` out 1: buffer can accept an instruction.
- `in_instr` in 32: raw instruction.
- `in_pc` in XLEN: PC of the instruction.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: execute consumes the head entry.
- `out_pc`, `out_imm` out XLEN each: PC and sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register indices.
- `out_aluOP` out 6: ALU operation code.
- `out_regWrite`, `out_memToReg`, `out_memWrite`, `out_operandA`, `out_operandB`, `out_jalrEN`, `out_jalEN`, `out_branchEN`, `out_illegal` out 1 each: control flags.

## Operation
- Decode is a combinational function of `in_instr` and is captured into the buffer on acceptance. Acceptance means `in_valid & in_ready & ~flush`.
- aluOP codes:
  - loads LB/LH/LW/LD/LBU/LHU/LWU: 0–4, 45, 46
  - OP-IMM: 5–13, with SRAI/SRLI selected by bit 30
  - AUIPC: 14
  - stores SB/SH/SW/SD: 15–17, 47
  - OP: 18–27, with SUB/SRA selected by bit 30
  - LUI: 28
  - branches BEQ/BNE/BLT/BGE/BLTU/BGEU: 29–34
  - JALR: 35
  - JAL: 36
  - M-extension MUL..REMU: 37–44
  - RV64 ADDIW/SLLIW/SRLIW/SRAIW/ADDW/SUBW/SLLW/SRLW/SRAW: 48–56
- Control flags by class:
  - regWrite: OP, OP-IMM, load, JALR, JAL, LUI, AUIPC.
  - memToReg: load.
  - memWrite: store.
  - operandA: every class except OP and branch.
  - operandB: AUIPC and JAL.
  - jalrEN, jalEN, branchEN: their own class only.
- Immediates follow the I/S/B/U/J formats and are sign-extended from the top immediate bit to XLEN. For U-type with XLEN=64, bits 63:32 are copies of bit 31.
- `out_rd` is 0 whenever regWrite=0, so stores and branches never name a destination.
- Illegal decode sets `out_illegal`=1 and forces every other control flag, aluOP and imm to 0. Illegal means any of:
  - unknown opcode, or a func3 value unassigned in that class
  - non-zero func7 other than the legal 0100000 / 0000001 cases
  - func7=0000001 with M_EXT=0
  - LD/SD/LWU or a W-opcode with XLEN=32
  - RV32 shift with imm[5]=1
- Buffer: two entries with head/tail pointers and a count of 0..2.
  - Push on acceptance; pop on `out_valid & out_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - `in_ready` = (count<2) & ~rst, driven from registered state only.
  - `out_valid` = (count>0); the `out_*` fields show the head entry.
- Flush: count becomes 0 at the next edge. Any instruction offered in the same cycle is dropped, and flush takes priority over a simultaneous pop.

## Timing
- Latency 1: an instruction accepted at edge N drives `out_valid` and its fields after edge N.
- Throughput is one instruction per cycle while `out_ready`=1.
- Reset values: count=0, `out_valid`=0, all `out_*` fields 0, `in_ready`=0 while `rst` is high.
- `in_ready`=1 from the first cycle after reset is released.
- `rst` asserted mid-stream discards all entries exactly as flush does.
- With the buffer full and `out_ready`=1, `in_ready` stays 0 that cycle. It does not combinationally follow `out_ready`, so no ready path runs straight through the block.
- Head fields remain stable while `out_valid & ~out_ready`.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode constants
  - aluOP code constants
  - the decoded-bundle struct (flags, aluOP, regs, imm)
- Sub-module `rv_decode_comb` is the pure decode function, instantiated once.
- The storage logic (two-entry skid buffer, pointers, count, flush) stays in `decode_pipe`.

## Test plan
- **ADDI, XLEN=32:** `0x00500093` (addi x1,x0,5), `out_ready`=1 → next cycle `out_valid`=1, imm=5, aluOP=5, rd=1, regWrite=1, operandA=1, illegal=0.
- **Branch:** `0xFE000EE3` (beq x0,x0,-4) → imm=`0xFFFFFFFC`, aluOP=29, branchEN=1, regWrite=0, rd=0.
- **Backpressure:** `out_ready`=0 and three back-to-back instructions A, B, C → A and B accepted, `in_ready` low for C. Raising `out_ready` then drains A, B, C in order, one per cycle.
- **Flush:** flush while full and with a new valid input → `out_valid`=0 next cycle and `in_ready`=1; nothing reappears afterwards.
- **Illegal:** `0xFFFFFFFF` → illegal=1 with all control flags 0. `0x02208033` (MUL) with M_EXT=0 → illegal=1; with M_EXT=1 → aluOP=37, regWrite=1.
- **RV64:** XLEN=64, `0x800000B7` (lui x1,0x80000) → imm=`0xFFFFFFFF80000000`, aluOP=28. Also `0x0000B083` (LD) is legal at XLEN=64 and illegal at XLEN=32.
